// File: rtl/nonstop_clock_mux_pkg.sv
`timescale 1ns/1ps
// nonstop_clock_mux_pkg: shared FSM state type and default parameters for the nonstop clock mux.
// No ports.
package nonstop_clock_mux_pkg;
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, ENABLE} state_t;
   localparam int DEF_STAGES = 2;
   localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/nonstop_clock_mux_if.sv
`timescale 1ns/1ps
// nonstop_clock_mux_if: select/output bundle of the nonstop clock mux.
// Signals: select (source choice, may be async), clock_out (muxed clock).
// With NONSTOP_CLOCK_MUX_STATUS_EN: active_source, switching, timeout_seen status outputs.
interface nonstop_clock_mux_if;
   logic select;
   logic clock_out;
`ifdef NONSTOP_CLOCK_MUX_STATUS_EN
   logic active_source;
   logic switching;
   logic timeout_seen;
   modport master(output select, input clock_out, active_source, switching, timeout_seen);
   modport slave(input select, output clock_out, active_source, switching, timeout_seen);
`else
   modport master(output select, input clock_out);
   modport slave(input select, output clock_out);
`endif
endinterface

// File: rtl/nonstop_clock_mux_gate.sv
`timescale 1ns/1ps
// nonstop_clock_mux_gate: glitch-free clock gate for one source.
// Ports: src_clock (source), resetn (async clear), enable (from control FSM),
// force_clear (async clear for a source stuck high), latched (gate state), gated (src_clock AND latched).
module nonstop_clock_mux_gate (
   input  logic src_clock,
   input  logic resetn,
   input  logic enable,
   input  logic force_clear,
   output logic latched,
   output logic gated
);
   // Transparent only while the source is low, so the gate never cuts a high phase short.
   always_latch
      if (!resetn || force_clear) latched <= 1'b0;
      else if (!src_clock) latched <= enable;
   assign gated = src_clock & latched;
endmodule

// File: rtl/nonstop_clock_mux_sync.sv
`timescale 1ns/1ps
// nonstop_clock_mux_sync: multi-flop synchronizer into the control clock domain.
// Ports: clock, resetn (async active-low), d (async input), q (synchronized output).
module nonstop_clock_mux_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH = 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [STAGES-1:0][WIDTH-1:0] pipe;
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) pipe <= '0;
      else pipe <= {pipe[STAGES-2:0], d};
   assign q = pipe[STAGES-1];
endmodule

// File: rtl/nonstop_clock_mux.sv
`timescale 1ns/1ps
// nonstop_clock_mux: glitch-free 2:1 clock mux that still switches when a source has stopped.
// Ports: clock (free-running control clock), resetn (async active-low), clock_0/clock_1 (sources),
// bus.select (0 = clock_0, 1 = clock_1), bus.clock_out (muxed clock).
// Optional macro NONSTOP_CLOCK_MUX_STATUS_EN adds bus.active_source, bus.switching, bus.timeout_seen.
module nonstop_clock_mux
   import nonstop_clock_mux_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic clock,
   input logic resetn,
   input logic clock_0,
   input logic clock_1,
   nonstop_clock_mux_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + STAGES + 2);
   state_t state;
   logic cur;
   logic sel_s;
   logic [1:0] en;
   logic [1:0] force_clr;
   logic [1:0] latched;
   logic [1:0] gated;
   logic [1:0] ack;
   logic [TW-1:0] timer;
   nonstop_clock_mux_sync #(.STAGES(STAGES), .WIDTH(3)) u_sync (
      .clock(clock), .resetn(resetn), .d({latched, bus.select}), .q({ack, sel_s})
   );
   nonstop_clock_mux_gate u_gate_0 (
      .src_clock(clock_0), .resetn(resetn), .enable(en[0]), .force_clear(force_clr[0]),
      .latched(latched[0]), .gated(gated[0])
   );
   nonstop_clock_mux_gate u_gate_1 (
      .src_clock(clock_1), .resetn(resetn), .enable(en[1]), .force_clear(force_clr[1]),
      .latched(latched[1]), .gated(gated[1])
   );
   assign bus.clock_out = |gated;
   // In DRAIN an ack of 0 is trusted only after the synchronizer has had time to see
   // the effect of the cleared enable; otherwise a stale 0 could let both gates open.
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         cur <= 1'b0;
         en <= '0;
         force_clr <= '0;
         timer <= '0;
      end else
         case (state)
            IDLE: begin
               en[sel_s] <= 1'b1;
               cur <= sel_s;
               state <= ACTIVE;
            end
            ACTIVE:
               if (sel_s != cur) begin
                  en[cur] <= 1'b0;
                  timer <= '0;
                  state <= DRAIN;
               end
            DRAIN:
               if (!ack[cur] && timer > TW'(STAGES)) state <= ENABLE;
               else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                  force_clr[cur] <= 1'b1;
                  state <= ENABLE;
               end else timer <= timer + 1'b1;
            default: begin
               force_clr <= '0;
               en[~cur] <= 1'b1;
               cur <= ~cur;
               state <= ACTIVE;
            end
         endcase
`ifdef NONSTOP_CLOCK_MUX_STATUS_EN
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         bus.active_source <= 1'b0;
         bus.switching <= 1'b0;
         bus.timeout_seen <= 1'b0;
      end else begin
         bus.active_source <= cur;
         bus.switching <= state != ACTIVE;
         bus.timeout_seen <= bus.timeout_seen | (|force_clr);
      end
`endif
endmodule

// File: tb/tb_nonstop_clock_mux.sv
`timescale 1ns/1ps
// tb_nonstop_clock_mux: self-checking bench for the nonstop clock mux.
module tb_nonstop_clock_mux;
   import nonstop_clock_mux_pkg::*;
   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic clock_0 = 1'b0;
   logic clock_1 = 1'b0;
   bit run_0 = 1'b1;
   bit run_1 = 1'b1;
   logic lvl_0 = 1'b0;
   logic lvl_1 = 1'b0;
   bit done = 1'b0;
   int passed = 0;
   int total = 0;
   real exp_q[$];
   typedef struct {
      bit  sel;
      bit  run_0;
      real period;
   } vec_t;
   vec_t vecs[22];
   nonstop_clock_mux_if bus();
   nonstop_clock_mux dut (
      .clock(clock), .resetn(resetn), .clock_0(clock_0), .clock_1(clock_1), .bus(bus)
   );
   always #2 clock = ~clock;
   always #5 clock_0 = run_0 ? ~clock_0 : lvl_0;
   always #1.5915 clock_1 = run_1 ? ~clock_1 : lvl_1;

   task automatic check_real(input string name, input real act, input real req);
      total++;
      if (act >= req * 0.95 && act <= req * 1.05) passed++;
      else $display("FAIL %s: measured %0.3f ns, expected %0.3f ns +/-5%%", name, act, req);
   endtask

   task automatic check_bits(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Average rising-edge period of clock_out over the window; 0 when no second edge is seen.
   task automatic measure(input real window, output real period);
      real t_first, t_last;
      int n;
      logic prev;
      n = 0;
      t_first = 0.0;
      t_last = 0.0;
      prev = bus.clock_out;
      for (int i = 0; i < int'(window * 10.0); i++) begin
         #0.1;
         if (bus.clock_out === 1'b1 && prev === 1'b0) begin
            if (n == 0) t_first = $realtime;
            t_last = $realtime;
            n++;
         end
         prev = bus.clock_out;
      end
      period = n > 1 ? (t_last - t_first) / (n - 1) : 0.0;
   endtask

   initial begin
      real p;
      for (int i = 0; i < 22; i++) begin
         vecs[i].sel = (i % 2 == 0);
         vecs[i].run_0 = (i < 11);
         vecs[i].period = vecs[i].sel ? 3.183 : (i < 11 ? 10.0 : 0.0);
      end
      bus.select = 1'b0;
      resetn = 1'b0;
      measure(30.0, p);
      check_real("reset_no_edges", p, 0.0);
      check_bits("reset_out_low", {7'd0, bus.clock_out}, 8'd0);
      resetn = 1'b1;
      #100;
      measure(150.0, p);
      check_real("after_reset_100mhz", p, 10.0);
      for (int i = 0; i < 22; i++) begin
         bus.select = vecs[i].sel;
         run_0 = vecs[i].run_0;
         exp_q.push_back(vecs[i].period);
         #100;
         measure(150.0, p);
         check_real($sformatf("vec%0d_sel%0d_run0_%0d", i, vecs[i].sel, vecs[i].run_0), p, exp_q.pop_front());
      end
      run_0 = 1'b1;
      bus.select = 1'b1;
      #100;
      measure(150.0, p);
      check_real("pre_stop_314mhz", p, 3.183);
      run_1 = 1'b0;
      lvl_1 = 1'b1;
      #10;
      bus.select = 1'b0;
      #150;
      check_bits("stuck_high_held", {7'd0, bus.clock_out}, 8'd1);
      #250;
      measure(150.0, p);
      check_real("post_timeout_100mhz", p, 10.0);
`ifdef NONSTOP_CLOCK_MUX_STATUS_EN
      check_bits("timeout_seen", {7'd0, bus.timeout_seen}, 8'd1);
      check_bits("active_source", {7'd0, bus.active_source}, 8'd0);
      check_bits("switching_idle", {7'd0, bus.switching}, 8'd0);
`endif
      run_1 = 1'b1;
      #50;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               bus.select = ~bus.select;
               #($urandom_range(0, 530) * 1.0);
            end
            #100;
            done = 1'b1;
         end
         begin
            real t_rise, w;
            while (!done) begin
               @(posedge bus.clock_out or posedge done);
               if (!done) begin
                  t_rise = $realtime;
                  @(negedge bus.clock_out or posedge done);
                  if (!done) begin
                     w = $realtime - t_rise;
                     check_real("high_phase", w, w > 3.0 ? 5.0 : 1.592);
                  end
               end
            end
         end
      join
      #100;
      bus.select = ~bus.select;
      for (int i = 0; i < 50 && dut.state != DRAIN; i++) @(negedge clock);
      check_bits("reached_drain", {7'd0, dut.state == DRAIN}, 8'd1);
      resetn = 1'b0;
      #0.1;
      check_bits("reset_drain_out", {7'd0, bus.clock_out}, 8'd0);
      check_bits("reset_drain_en", {6'd0, dut.en}, 8'd0);
      measure(50.0, p);
      check_real("reset_drain_quiet", p, 0.0);
      check_bits("reset_drain_out_held", {7'd0, bus.clock_out}, 8'd0);
      resetn = 1'b1;
      #100;
      measure(150.0, p);
      check_real("recover_after_reset", p, bus.select ? 3.183 : 10.0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
